// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect, and the decode-side queue head.
// master = fetch unit, slave = memory/decode environment.
interface fetch_unit_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, returned words queued with their PC for decode.
// state | meaning
// S_REQ | request word at fpc while the queue has room
// S_RSP | request granted, waiting for rvalid (drop=1 discards it after a redirect)
module fetch_unit #(
    parameter int            DW       = 32,
    parameter int            AW       = 32,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         rst,
    fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_REQ, S_RSP} state_t;

    state_t        state;
    logic          drop;
    logic [AW-1:0] fpc;
    logic [AW-1:0] req_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [DW-1:0] mem_instr [DEPTH];
    logic [AW-1:0] mem_pc    [DEPTH];

    logic can_req;
    logic grant;
    logic push;
    logic pop;

    assign can_req         = (count < CW'(DEPTH));
    assign bus.imem_req    = (state == S_REQ) && can_req && !rst;
    assign bus.imem_addr   = {fpc[AW-1:2], 2'b00};
    assign grant           = bus.imem_req && bus.imem_gnt;
    assign push            = (state == S_RSP) && bus.imem_rvalid && !drop;
    assign bus.instr_valid = (count != '0) && !rst;
    assign pop             = bus.instr_valid && bus.instr_ready;
    assign bus.instr       = mem_instr[rd_ptr];
    assign bus.instr_pc    = mem_pc[rd_ptr];

    // Queue storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (!rst && !bus.redirect && push) begin
            mem_instr[wr_ptr] <= bus.imem_rdata;
            mem_pc[wr_ptr]    <= req_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_REQ;
            drop   <= 1'b0;
            fpc    <= RESET_PC;
            req_pc <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            // Redirect flushes the queue; whatever is in flight must be thrown away.
            fpc    <= {bus.redirect_pc[AW-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            case (state)
                S_REQ: begin
                    if (grant) begin
                        state <= S_RSP;
                        drop  <= 1'b1;
                    end
                end
                S_RSP: begin
                    if (bus.imem_rvalid) begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (grant) begin
                        req_pc <= fpc;
                        fpc    <= fpc + AW'(4);
                        state  <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (bus.imem_rvalid) begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                    end
                end
            endcase
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, backpressure, redirect cases and PC wrap.
module tb_fetch_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_unit_if #(.DW(32), .AW(32)) bus ();
    fetch_unit_if #(.DW(32), .AW(32)) bus2 ();

    fetch_unit #(.DW(32), .AW(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .bus(bus.master));
    fetch_unit #(.DW(32), .AW(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mkword(input logic [31:0] a);
        return a ^ 32'h1357_2468;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One grant followed by rvalid on the next cycle.
    task automatic fetch_word(input logic [31:0] data);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        tick();
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req cyc%0d actual=%b expected=0", i, bus.imem_req); end
            checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid cyc%0d actual=%b expected=0", i, bus.instr_valid); end
        end
        rst = 1'b0;
        tick();
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL post_rst_req actual=%b expected=1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL post_rst_addr actual=%h expected=00000000", bus.imem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid actual=%b expected=0", bus.instr_valid); end
        checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL post_rst_addr2 actual=%h expected=fffffffc", bus2.imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] words [3];
        words[0] = 32'h0050_0093;
        words[1] = 32'h0010_0113;
        words[2] = 32'h0020_81B3;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL stream_req%0d actual=%b/%h expected=1/%h", i, bus.imem_req, bus.imem_addr, 32'(4 * i)); end
            bus.imem_gnt = 1'b1;
            tick();
            bus.imem_gnt = 1'b0;
            checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_wait%0d actual=req%b/valid%b expected=0/0", i, bus.imem_req, bus.instr_valid); end
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = words[i];
            tick();
            bus.imem_rvalid = 1'b0;
            checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== words[i] || bus.instr_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_out%0d actual=%b/%h/%h expected=1/%h/%h", i, bus.instr_valid, bus.instr, bus.instr_pc, words[i], 32'(4 * i)); end
        end
        tick();
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_drain actual=%b expected=0", bus.instr_valid); end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int          grants;
        logic [31:0] a;
        grants = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.imem_req !== 1'b1) break;
            a = bus.imem_addr;
            checks++; if (a !== 32'h0C + 32'(4 * k)) begin errors++; $display("FAIL bp_addr%0d actual=%h expected=%h", k, a, 32'h0C + 32'(4 * k)); end
            fetch_word(mkword(a));
            grants++;
        end
        checks++; if (grants !== 4) begin errors++; $display("FAIL bp_grants actual=%0d expected=4", grants); end
        tick(); tick(); tick();
        checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL bp_full actual=req%b/valid%b expected=0/1", bus.imem_req, bus.instr_valid); end
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = 32'h0C + 32'(4 * k);
            checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== a || bus.instr !== mkword(a)) begin errors++; $display("FAIL bp_pop%0d actual=%b/%h/%h expected=1/%h/%h", k, bus.instr_valid, bus.instr_pc, bus.instr, a, mkword(a)); end
            tick();
        end
        bus.instr_ready = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1C) begin errors++; $display("FAIL bp_resume actual=%b/%b/%h expected=0/1/0000001c", bus.instr_valid, bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_redirect_drop();
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h43;
        tick();
        bus.redirect = 1'b0;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rd_wait_req actual=%b expected=0", bus.imem_req); end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rd_dropped actual=%b expected=0", bus.instr_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin errors++; $display("FAIL rd_newaddr actual=%b/%h expected=1/00000040", bus.imem_req, bus.imem_addr); end
        fetch_word(mkword(32'h40));
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40 || bus.instr !== mkword(32'h40)) begin errors++; $display("FAIL rd_first actual=%b/%h/%h expected=1/00000040/%h", bus.instr_valid, bus.instr_pc, bus.instr, mkword(32'h40)); end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rd_empty actual=%b expected=0", bus.instr_valid); end
    endtask

    task automatic test_redirect_coincident();
        // redirect together with grant
        checks++; if (bus.imem_addr !== 32'h44) begin errors++; $display("FAIL rc_start actual=%h expected=00000044", bus.imem_addr); end
        bus.imem_gnt    = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        tick();
        bus.imem_gnt = 1'b0;
        bus.redirect = 1'b0;
        checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rc_gnt_wait actual=%b/%b expected=0/0", bus.imem_req, bus.instr_valid); end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_0001;
        tick();
        bus.imem_rvalid = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rc_gnt actual=%b/%b/%h expected=0/1/00000100", bus.instr_valid, bus.imem_req, bus.imem_addr); end
        // redirect together with rvalid
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_0002;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        tick();
        bus.imem_rvalid = 1'b0;
        bus.redirect    = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin errors++; $display("FAIL rc_rvalid actual=%b/%b/%h expected=0/1/00000200", bus.instr_valid, bus.imem_req, bus.imem_addr); end
        for (int k = 0; k < 3; k++) fetch_word(mkword(32'h200 + 32'(4 * k)));
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h200 || bus.instr !== mkword(32'h200)) begin errors++; $display("FAIL rc_fill actual=%b/%h/%h expected=1/00000200/%h", bus.instr_valid, bus.instr_pc, bus.instr, mkword(32'h200)); end
        // redirect together with a pop on a 3-entry queue
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h300;
        tick();
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin errors++; $display("FAIL rc_pop actual=%b/%b/%h expected=0/1/00000300", bus.instr_valid, bus.imem_req, bus.imem_addr); end
        tick(); tick();
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rc_stale actual=%b expected=0", bus.instr_valid); end
        fetch_word(mkword(32'h300));
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h300 || bus.instr !== mkword(32'h300)) begin errors++; $display("FAIL rc_after actual=%b/%h/%h expected=1/00000300/%h", bus.instr_valid, bus.instr_pc, bus.instr, mkword(32'h300)); end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 2; k++) begin
            bus2.imem_gnt = 1'b1;
            tick();
            bus2.imem_gnt    = 1'b0;
            bus2.imem_rvalid = 1'b1;
            bus2.imem_rdata  = mkword(32'hFFFF_FFFC + 32'(4 * k));
            tick();
            bus2.imem_rvalid = 1'b0;
            checks++; if (bus2.imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL wrap_addr%0d actual=%h expected=%h", k, bus2.imem_addr, 32'(4 * k)); end
        end
        checks++; if (bus2.instr_valid !== 1'b1 || bus2.instr_pc !== 32'hFFFF_FFFC || bus2.instr !== mkword(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_head actual=%b/%h/%h expected=1/fffffffc/%h", bus2.instr_valid, bus2.instr_pc, bus2.instr, mkword(32'hFFFF_FFFC)); end
        bus2.instr_ready = 1'b1;
        tick();
        bus2.instr_ready = 1'b0;
        checks++; if (bus2.instr_valid !== 1'b1 || bus2.instr_pc !== 32'h0 || bus2.instr !== mkword(32'h0)) begin errors++; $display("FAIL wrap_next actual=%b/%h/%h expected=1/00000000/%h", bus2.instr_valid, bus2.instr_pc, bus2.instr, mkword(32'h0)); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.imem_gnt     = 1'b0;  bus2.imem_gnt     = 1'b0;
        bus.imem_rvalid  = 1'b0;  bus2.imem_rvalid  = 1'b0;
        bus.imem_rdata   = '0;    bus2.imem_rdata   = '0;
        bus.redirect     = 1'b0;  bus2.redirect     = 1'b0;
        bus.redirect_pc  = '0;    bus2.redirect_pc  = '0;
        bus.instr_ready  = 1'b0;  bus2.instr_ready  = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_coincident();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
